// File: rtl/bp_table.sv
// bp_table: branch-prediction table of saturating up/down counters.
// Lookups from fetch return the selected counter one cycle later; updates
// from execute train one counter, shift the global history and count
// mispredictions. With GSHARE=1 the lookup index is the PC index XORed with
// the global history.
//
// state (per entry) | meaning
// 0                 | strongly not-taken
// 2^(CTR_W-1)-1     | weakly not-taken (reset value)
// 2^(CTR_W-1)       | weakly taken
// 2^CTR_W-1         | strongly taken
module bp_table #(
    parameter int CTR_W  = 2,
    parameter int IDX_W  = 4,
    parameter int GSHARE = 0,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lookup_valid,
    input  logic [31:0]       lookup_pc,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [CTR_W-1:0]  pred_ctr,
    output logic [IDX_W-1:0]  pred_idx,
    input  logic              update_valid,
    input  logic [IDX_W-1:0]  update_idx,
    input  logic              update_taken,
    input  logic              update_pred,
    output logic [IDX_W-1:0]  ghr,
    output logic [STAT_W-1:0] mispredicts
);

    localparam int DEPTH = 2 ** IDX_W;

    localparam logic [CTR_W-1:0]  CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0]  CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0]  CTR_ZERO = {CTR_W{1'b0}};
    localparam logic [CTR_W-1:0]  CTR_ONE  = {{(CTR_W-1){1'b0}}, 1'b1};
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
    localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    logic [CTR_W-1:0]  r_table [DEPTH];
    logic [IDX_W-1:0]  r_ghr;
    logic [STAT_W-1:0] r_mis;
    logic              r_pred_valid;
    logic              r_pred_taken;
    logic [CTR_W-1:0]  r_pred_ctr;
    logic [IDX_W-1:0]  r_pred_idx;

    logic [IDX_W-1:0]  w_pc_idx;
    logic [IDX_W-1:0]  w_lookup_idx;
    logic [CTR_W-1:0]  w_lookup_ctr;
    logic [CTR_W-1:0]  w_upd_cur;
    logic [CTR_W-1:0]  w_upd_next;
    logic [IDX_W:0]    w_ghr_shift;
    logic              w_mispredict;
    logic              w_unused_pc;

    // Word-aligned PCs: the low two bits and the bits above the index carry
    // no information for the table.
    assign w_pc_idx    = lookup_pc[IDX_W+1:2];
    assign w_unused_pc = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0]};

    // Lookup index uses the history as it stood before this edge's update.
    assign w_lookup_idx = (GSHARE != 0) ? (w_pc_idx ^ r_ghr) : w_pc_idx;
    assign w_lookup_ctr = r_table[w_lookup_idx];

    // Concatenate then truncate so the oldest history bit falls off; this
    // form also stays legal for a one-bit history.
    assign w_ghr_shift  = {r_ghr, update_taken};
    assign w_mispredict = update_valid && (update_pred != update_taken);

    // Saturating next value for the entry being trained.
    always_comb begin
        w_upd_cur  = r_table[update_idx];
        w_upd_next = w_upd_cur;
        if (update_taken) begin
            if (w_upd_cur != CTR_MAX) begin
                w_upd_next = w_upd_cur + CTR_ONE;
            end
        end else begin
            if (w_upd_cur != CTR_ZERO) begin
                w_upd_next = w_upd_cur - CTR_ONE;
            end
        end
    end

    // Counter storage: all entries return to weakly not-taken on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= CTR_INIT;
            end
        end else if (update_valid) begin
            r_table[update_idx] <= w_upd_next;
        end
    end

    // Global history: newest resolved outcome enters at bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ghr <= '0;
        end else if (update_valid) begin
            r_ghr <= w_ghr_shift[IDX_W-1:0];
        end
    end

    // Mispredict statistics, held at the top value instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mis <= '0;
        end else if (w_mispredict && (r_mis != STAT_MAX)) begin
            r_mis <= r_mis + STAT_ONE;
        end
    end

    // Prediction register: read-before-write, so a same-cycle update to the
    // same entry is not visible until the next lookup.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_ctr   <= '0;
            r_pred_idx   <= '0;
        end else begin
            r_pred_valid <= lookup_valid;
            if (lookup_valid) begin
                r_pred_taken <= w_lookup_ctr[CTR_W-1];
                r_pred_ctr   <= w_lookup_ctr;
                r_pred_idx   <= w_lookup_idx;
            end
        end
    end

    assign pred_valid  = r_pred_valid;
    assign pred_taken  = r_pred_taken;
    assign pred_ctr    = r_pred_ctr;
    assign pred_idx    = r_pred_idx;
    assign ghr         = r_ghr;
    assign mispredicts = r_mis;

endmodule

// File: tb/tb_bp_table.sv
// Testbench for bp_table: two instances (A: 2-bit counters, PC indexing,
// 2-bit statistics; B: 3-bit counters, gshare indexing, 16-bit statistics)
// share one stimulus stream. A directed vector table, hand sequences and a
// randomized phase are checked against constants and a behavioural model.
module tb_bp_table;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        update_valid = 1'b0;
    logic [3:0]  update_idx = '0;
    logic        update_taken = 1'b0;
    logic        update_pred = 1'b0;

    logic        a_pv, a_tk, b_pv, b_tk;
    logic [1:0]  a_ctr;
    logic [2:0]  b_ctr;
    logic [3:0]  a_idx, b_idx, a_ghr, b_ghr;
    logic [1:0]  a_mis;
    logic [15:0] b_mis;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bp_table #(.CTR_W(2), .IDX_W(4), .GSHARE(0), .STAT_W(2)) u_a (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_valid(a_pv), .pred_taken(a_tk), .pred_ctr(a_ctr), .pred_idx(a_idx),
        .update_valid(update_valid), .update_idx(update_idx),
        .update_taken(update_taken), .update_pred(update_pred),
        .ghr(a_ghr), .mispredicts(a_mis)
    );

    bp_table #(.CTR_W(3), .IDX_W(4), .GSHARE(1), .STAT_W(16)) u_b (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_valid(b_pv), .pred_taken(b_tk), .pred_ctr(b_ctr), .pred_idx(b_idx),
        .update_valid(update_valid), .update_idx(update_idx),
        .update_taken(update_taken), .update_pred(update_pred),
        .ghr(b_ghr), .mispredicts(b_mis)
    );

    // Behavioural model: per instance, a plain array of counter values.
    int cw[2]   = '{2, 3};
    int gs[2]   = '{0, 1};
    int smax[2] = '{3, 65535};
    int m_tbl[2][16];
    int m_ghr[2], m_mis[2], m_pv[2], m_ctr[2], m_tk[2], m_idx[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int e = 0; e < 16; e++) m_tbl[k][e] = (1 << (cw[k] - 1)) - 1;
            m_ghr[k] = 0; m_mis[k] = 0;
            m_pv[k] = 0; m_ctr[k] = 0; m_tk[k] = 0; m_idx[k] = 0;
        end
    endtask

    task automatic model_step();
        int pidx, u, maxc;
        for (int k = 0; k < 2; k++) begin
            pidx = (int'(lookup_pc) >> 2) & 15;
            if (gs[k] != 0) pidx = pidx ^ m_ghr[k];
            if (lookup_valid) begin
                m_ctr[k] = m_tbl[k][pidx];
                m_tk[k]  = (m_ctr[k] >= (1 << (cw[k] - 1))) ? 1 : 0;
                m_idx[k] = pidx;
                m_pv[k]  = 1;
            end else begin
                m_pv[k] = 0;
            end
            if (update_valid) begin
                u = int'(update_idx);
                maxc = (1 << cw[k]) - 1;
                if (update_taken) m_tbl[k][u] = (m_tbl[k][u] < maxc) ? m_tbl[k][u] + 1 : maxc;
                else              m_tbl[k][u] = (m_tbl[k][u] > 0) ? m_tbl[k][u] - 1 : 0;
                m_ghr[k] = ((m_ghr[k] * 2) + int'(update_taken)) % 16;
                if (update_pred != update_taken)
                    m_mis[k] = (m_mis[k] < smax[k]) ? m_mis[k] + 1 : smax[k];
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic chk_a_model();
        chk("a_pred_valid", int'(a_pv), m_pv[0]);
        chk("a_pred_taken", int'(a_tk), m_tk[0]);
        chk("a_pred_ctr",   int'(a_ctr), m_ctr[0]);
        chk("a_pred_idx",   int'(a_idx), m_idx[0]);
        chk("a_ghr",        int'(a_ghr), m_ghr[0]);
        chk("a_mispredicts", int'(a_mis), m_mis[0]);
    endtask

    task automatic chk_b_model();
        chk("b_pred_valid", int'(b_pv), m_pv[1]);
        chk("b_pred_taken", int'(b_tk), m_tk[1]);
        chk("b_pred_ctr",   int'(b_ctr), m_ctr[1]);
        chk("b_pred_idx",   int'(b_idx), m_idx[1]);
        chk("b_ghr",        int'(b_ghr), m_ghr[1]);
        chk("b_mispredicts", int'(b_mis), m_mis[1]);
    endtask

    task automatic drive(input logic lv, input logic [31:0] pc, input logic uv,
                         input logic [3:0] ui, input logic ut, input logic up);
        lookup_valid = lv; lookup_pc = pc;
        update_valid = uv; update_idx = ui; update_taken = ut; update_pred = up;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Directed vectors with hand-derived expectations for instance A.
    typedef struct {
        logic        lv;
        logic [31:0] pc;
        logic        uv;
        logic [3:0]  ui;
        logic        ut;
        logic        up;
        int          pv, ctr, tk, idx, ghr, mis;
    } vec_t;

    vec_t vecs[20];

    task automatic setv(input int i, input logic lv, input logic [31:0] pc, input logic uv,
                        input logic [3:0] ui, input logic ut, input logic up,
                        input int pv, input int ctr, input int tk, input int idx,
                        input int g, input int mis);
        vecs[i].lv = lv; vecs[i].pc = pc; vecs[i].uv = uv; vecs[i].ui = ui;
        vecs[i].ut = ut; vecs[i].up = up;
        vecs[i].pv = pv; vecs[i].ctr = ctr; vecs[i].tk = tk; vecs[i].idx = idx;
        vecs[i].ghr = g; vecs[i].mis = mis;
    endtask

    initial begin
        //      lv  pc            uv idx ut up   pv ctr tk idx ghr mis
        setv(0,  1, 32'h10,        0, 0, 0, 0,   1, 1, 0, 4,  0, 0);
        setv(1,  1, 32'h10,        1, 4, 1, 1,   1, 1, 0, 4,  1, 0);
        setv(2,  1, 32'h10,        1, 4, 1, 1,   1, 2, 1, 4,  3, 0);
        setv(3,  1, 32'h10,        1, 4, 1, 1,   1, 3, 1, 4,  7, 0);
        setv(4,  1, 32'h10,        1, 4, 1, 1,   1, 3, 1, 4, 15, 0);
        setv(5,  1, 32'h10,        0, 0, 0, 0,   1, 3, 1, 4, 15, 0);
        setv(6,  1, 32'h10,        1, 4, 0, 0,   1, 3, 1, 4, 14, 0);
        setv(7,  1, 32'h10,        1, 4, 0, 0,   1, 2, 1, 4, 12, 0);
        setv(8,  1, 32'h10,        1, 4, 0, 0,   1, 1, 0, 4,  8, 0);
        setv(9,  1, 32'h10,        1, 4, 0, 0,   1, 0, 0, 4,  0, 0);
        setv(10, 1, 32'h10,        0, 0, 0, 0,   1, 0, 0, 4,  0, 0);
        setv(11, 0, 32'h0,         1, 9, 1, 0,   0, 0, 0, 4,  1, 1);
        setv(12, 0, 32'h0,         1, 9, 1, 0,   0, 0, 0, 4,  3, 2);
        setv(13, 0, 32'h0,         1, 9, 0, 1,   0, 0, 0, 4,  6, 3);
        setv(14, 0, 32'h0,         1, 9, 1, 0,   0, 0, 0, 4, 13, 3);
        setv(15, 0, 32'h0,         1, 9, 0, 1,   0, 0, 0, 4, 10, 3);
        setv(16, 0, 32'h0,         1, 9, 1, 1,   0, 0, 0, 4,  5, 3);
        setv(17, 1, 32'h24,        0, 0, 0, 0,   1, 3, 1, 9,  5, 3);
        setv(18, 1, 32'hABCD_0127, 0, 0, 0, 0,   1, 3, 1, 9,  5, 3);
        setv(19, 0, 32'h0,         0, 0, 0, 0,   0, 3, 1, 9,  5, 3);

        // Reset state.
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_pv", int'(a_pv), 0);
        chk("rst_a_ctr", int'(a_ctr), 0);
        chk("rst_a_idx", int'(a_idx), 0);
        chk("rst_a_ghr", int'(a_ghr), 0);
        chk("rst_a_mis", int'(a_mis), 0);
        chk_b_model();
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].lv, vecs[i].pc, vecs[i].uv, vecs[i].ui, vecs[i].ut, vecs[i].up);
            tick();
            chk($sformatf("vec%0d_pv", i),  int'(a_pv),  vecs[i].pv);
            chk($sformatf("vec%0d_ctr", i), int'(a_ctr), vecs[i].ctr);
            chk($sformatf("vec%0d_tk", i),  int'(a_tk),  vecs[i].tk);
            chk($sformatf("vec%0d_idx", i), int'(a_idx), vecs[i].idx);
            chk($sformatf("vec%0d_ghr", i), int'(a_ghr), vecs[i].ghr);
            chk($sformatf("vec%0d_mis", i), int'(a_mis), vecs[i].mis);
            chk_b_model();
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            tick();
            chk_a_model();
            chk_b_model();
        end

        // Mid-stream asynchronous reset after training idx 7 up to 3.
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #2;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 1, 7, 1, 0);
        tick();
        drive(1, 32'h1C, 1, 7, 1, 0);
        tick();
        chk("train7_ctr_pre", int'(a_ctr), 2);
        drive(1, 32'h1C, 0, 0, 0, 0);
        tick();
        chk("train7_ctr", int'(a_ctr), 3);
        chk("train7_mis", int'(a_mis), 2);
        chk_b_model();
        drive(0, 0, 0, 0, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_a_pv", int'(a_pv), 0);
        chk("midrst_a_ghr", int'(a_ghr), 0);
        chk("midrst_a_mis", int'(a_mis), 0);
        chk("midrst_a_ctr", int'(a_ctr), 0);
        chk("midrst_b_pv", int'(b_pv), 0);
        chk("midrst_b_ghr", int'(b_ghr), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(1, 32'h1C, 0, 0, 0, 0);
        tick();
        chk("postrst_a_ctr", int'(a_ctr), 1);
        chk("postrst_a_pv", int'(a_pv), 1);
        chk("postrst_b_ctr", int'(b_ctr), 3);
        chk("postrst_b_idx", int'(b_idx), 7);
        chk_a_model();

        // Gshare: history T,T,N,T -> 1101, then PC index 2 gives 1111.
        drive(0, 0, 1, 0, 1, 1); tick();
        drive(0, 0, 1, 0, 1, 1); tick();
        drive(0, 0, 1, 0, 0, 0); tick();
        drive(0, 0, 1, 0, 1, 1); tick();
        chk("gs_b_ghr", int'(b_ghr), 13);
        drive(1, 32'h08, 0, 0, 0, 0);
        tick();
        chk("gs_b_idx", int'(b_idx), 15);
        chk("gs_b_ctr", int'(b_ctr), 3);
        chk("gs_a_idx", int'(a_idx), 2);
        chk_a_model();
        chk_b_model();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
